// File: rtl/fornecedor_instrucoes_if.sv
// fornecedor_instrucoes_if: DIN/Run/Done bus between the instruction source and the processor
//   din  : instruction or immediate word (source -> processor)
//   run  : one-cycle issue strobe (source -> processor)
//   done : instruction-complete strobe (processor -> source)
interface fornecedor_instrucoes_if;
    logic [15:0] din;
    logic        run;
    logic        done;
    modport master (output din, output run, input done);
    modport slave  (input din, input run, output done);
endinterface

// File: rtl/fornecedor_instrucoes.sv
// fornecedor_instrucoes: program memory + PC that issues instructions to the multicycle processor
//   clk, rst            : clock, async active-high reset
//   start_i             : run program from address 0 (accepted in IDLE/HALT)
//   load_i/load_addr_i/load_data_i : program memory write (accepted in IDLE/HALT)
//   pc_o                : address of current instruction
//   busy_o/halted_o     : executing / stopped on sentinel or timeout
//   error_o             : sticky Done-timeout flag
//   bus (master)        : din/run out, done in
module fornecedor_instrucoes #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     load_i,
    input  logic [AW-1:0]            load_addr_i,
    input  logic [15:0]              load_data_i,
    output logic [AW-1:0]            pc_o,
    output logic                     busy_o,
    output logic                     halted_o,
    output logic                     error_o,
    fornecedor_instrucoes_if.master  bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, HALT} state_t;
    localparam logic [15:0]   HALT_WORD = 16'hFFFF;
    localparam logic [AW-1:0] PC_ONE    = AW'(1);
    localparam logic [AW-1:0] PC_TWO    = AW'(2);
    logic [15:0]   mem_q [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [15:0]   din_q, din_d;
    logic          run_q, run_d, busy_q, busy_d, halted_q, halted_d, error_q, error_d;
    logic [15:0]   cur_word, next_word, next_imm;
    logic          idle_or_halt, can_start, timeout;
    assign idle_or_halt = state_q == IDLE || state_q == HALT;
    assign can_start    = start_i && idle_or_halt;
    assign timeout      = !bus.done && (cnt_q + 8'd1 == 8'(TIMEOUT));
    assign cur_word     = mem_q[pc_q];
    // Outputs are registered, so they are computed from the next state and next PC.
    assign next_word    = mem_q[pc_d];
    assign next_imm     = mem_q[pc_d + PC_ONE];
    // Start wins over a simultaneous Load.
    always_ff @(posedge clk)
        if (load_i && idle_or_halt && !start_i)
            mem_q[load_addr_i] <= load_data_i;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            din_q    <= din_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALT:
                if (start_i) begin
                    state_d = ISSUE;
                    pc_d    = '0;
                end
            ISSUE: begin
                // Done during the issue cycle belongs to no instruction and is ignored.
                cnt_d   = '0;
                state_d = cur_word == HALT_WORD ? HALT : cur_word[8:6] == 3'b001 ? IMM : WAIT;
            end
            IMM, WAIT:
                if (bus.done) begin
                    state_d = ISSUE;
                    pc_d    = pc_q + (state_q == IMM ? PC_TWO : PC_ONE);
                    cnt_d   = '0;
                end else if (timeout)
                    state_d = HALT;
                else
                    cnt_d = cnt_q + 8'd1;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        run_d    = state_d == ISSUE && next_word != HALT_WORD;
        din_d    = state_d == ISSUE ? next_word : state_d == IMM ? next_imm : state_d == WAIT ? din_q : 16'h0;
        busy_d   = state_d == ISSUE || state_d == IMM || state_d == WAIT;
        halted_d = state_d == HALT;
        error_d  = can_start ? 1'b0 : (state_q == IMM || state_q == WAIT) && timeout ? 1'b1 : error_q;
    end
    assign bus.din  = din_q;
    assign bus.run  = run_q;
    assign pc_o     = pc_q;
    assign busy_o   = busy_q;
    assign halted_o = halted_q;
    assign error_o  = error_q;
endmodule
